// File: rtl/eeprom_selftest_ctrl.sv
// -----------------------------------------------------------------------------
// eeprom_selftest_ctrl
//
// Write/read-back self-test sequencer for an I2C EEPROM driven through a
// single-byte I2C master. A start pulse writes NUM_BYTES pattern bytes
// beginning at START_ADDR, waits the EEPROM write-cycle time after each
// write, then reads every byte back and compares it with the pattern. The
// outcome is presented as a level (rw_done) plus a pass/fail flag for the
// LED alarm block.
//
// Pattern: data[i] = (START_ADDR + i) ^ SEED, all arithmetic 8-bit, so the
// addresses wrap from 8'hFF to 8'h00.
//
// Ports
//   clk        in   system clock
//   rst_n      in   asynchronous reset, active-low
//   start      in   1-cycle pulse, begins a run (accepted in IDLE/DONE only)
//   i2c_busy   in   master busy; no request is launched while high
//   i2c_done   in   1-cycle pulse, current transaction finished
//   i2c_err    in   qualifies i2c_done: NACK or bus error
//   i2c_rdata  in   read data, qualified by i2c_done on reads
//   i2c_req    out  1-cycle pulse, launches a transaction
//   i2c_rw     out  0 = write, 1 = read; held from i2c_req to i2c_done
//   i2c_addr   out  EEPROM word address; held like i2c_rw
//   i2c_wdata  out  write data; held like i2c_rw
//   busy       out  high in every state except IDLE and DONE
//   rw_done    out  level, high in DONE until the next start or reset
//   rw_result  out  valid while rw_done: 1 pass, 0 fail
//   fail_idx   out  0-based byte index of the first failure, 0 on pass
// -----------------------------------------------------------------------------
module eeprom_selftest_ctrl #(
  parameter int         NUM_BYTES   = 8,
  parameter logic [7:0] START_ADDR  = 8'h00,
  parameter logic [7:0] SEED        = 8'hA5,
  parameter int         WR_CYC      = 250_000,
  parameter int         TIMEOUT_CYC = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       i2c_busy,
  input  logic       i2c_done,
  input  logic       i2c_err,
  input  logic [7:0] i2c_rdata,
  output logic       i2c_req,
  output logic       i2c_rw,
  output logic [7:0] i2c_addr,
  output logic [7:0] i2c_wdata,
  output logic       busy,
  output logic       rw_done,
  output logic       rw_result,
  output logic [7:0] fail_idx
);

  // Counter widths sized from their terminal counts.
  localparam int GAP_W = $clog2(WR_CYC + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(WR_CYC - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
  localparam logic [7:0]       IDX_LAST = 8'(NUM_BYTES - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_WAIT = 3'd2,
    ST_WR_GAP  = 3'd3,
    ST_RD_REQ  = 3'd4,
    ST_RD_WAIT = 3'd5,
    ST_CMP     = 3'd6,
    ST_DONE    = 3'd7
  } state_t;

  // EEPROM word address of byte idx (8-bit wrap).
  function automatic logic [7:0] addr_f(input logic [7:0] idx);
    addr_f = START_ADDR + idx;
  endfunction

  // Expected data byte for byte idx.
  function automatic logic [7:0] pattern_f(input logic [7:0] idx);
    pattern_f = addr_f(idx) ^ SEED;
  endfunction

  state_t             state_r, state_s;
  logic [7:0]         idx_r, idx_s;
  logic [GAP_W-1:0]   gap_r, gap_s;
  logic [TMO_W-1:0]   tmo_r, tmo_s;
  logic [7:0]         rdata_r, rdata_s;
  logic               req_r, req_s;
  logic               rw_r, rw_s;
  logic [7:0]         addr_r, addr_s;
  logic [7:0]         wdata_r, wdata_s;
  logic               busy_r, busy_s;
  logic               done_r, done_s;
  logic               result_r, result_s;
  logic [7:0]         fidx_r, fidx_s;
  logic               fail_s;
  logic               pass_s;

  // Next-state and next-register computation for the whole sequencer.
  always_comb begin
    state_s  = state_r;
    idx_s    = idx_r;
    gap_s    = gap_r;
    tmo_s    = tmo_r;
    rdata_s  = rdata_r;
    req_s    = 1'b0;
    rw_s     = rw_r;
    addr_s   = addr_r;
    wdata_s  = wdata_r;
    done_s   = done_r;
    result_s = result_r;
    fidx_s   = fidx_r;
    fail_s   = 1'b0;
    pass_s   = 1'b0;

    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_s  = ST_WR_REQ;
          done_s   = 1'b0;
          result_s = 1'b0;
          fidx_s   = 8'd0;
          idx_s    = 8'd0;
          gap_s    = '0;
        end else begin
          state_s = state_r;
        end
      end

      ST_WR_REQ: begin
        if (!i2c_busy) begin
          req_s   = 1'b1;
          rw_s    = 1'b0;
          addr_s  = addr_f(idx_r);
          wdata_s = pattern_f(idx_r);
          tmo_s   = '0;
          state_s = ST_WR_WAIT;
        end else begin
          state_s = state_r;
        end
      end

      // A done pulse on the terminal-count cycle is still accepted.
      ST_WR_WAIT: begin
        if (i2c_done) begin
          if (i2c_err) begin
            fail_s = 1'b1;
          end else begin
            gap_s   = '0;
            state_s = ST_WR_GAP;
          end
        end else if (tmo_r == TMO_LAST) begin
          fail_s = 1'b1;
        end else begin
          tmo_s = tmo_r + TMO_ONE;
        end
      end

      // Hold off the next access for the EEPROM internal write cycle.
      ST_WR_GAP: begin
        if (gap_r == GAP_LAST) begin
          gap_s = '0;
          if (idx_r == IDX_LAST) begin
            idx_s   = 8'd0;
            state_s = ST_RD_REQ;
          end else begin
            idx_s   = idx_r + 8'd1;
            state_s = ST_WR_REQ;
          end
        end else begin
          gap_s = gap_r + GAP_ONE;
        end
      end

      ST_RD_REQ: begin
        if (!i2c_busy) begin
          req_s   = 1'b1;
          rw_s    = 1'b1;
          addr_s  = addr_f(idx_r);
          tmo_s   = '0;
          state_s = ST_RD_WAIT;
        end else begin
          state_s = state_r;
        end
      end

      ST_RD_WAIT: begin
        if (i2c_done) begin
          if (i2c_err) begin
            fail_s = 1'b1;
          end else begin
            rdata_s = i2c_rdata;
            state_s = ST_CMP;
          end
        end else if (tmo_r == TMO_LAST) begin
          fail_s = 1'b1;
        end else begin
          tmo_s = tmo_r + TMO_ONE;
        end
      end

      ST_CMP: begin
        if (rdata_r != pattern_f(idx_r)) begin
          fail_s = 1'b1;
        end else if (idx_r == IDX_LAST) begin
          pass_s = 1'b1;
        end else begin
          idx_s   = idx_r + 8'd1;
          state_s = ST_RD_REQ;
        end
      end

      default: begin
        state_s = ST_IDLE;
      end
    endcase

    // Result reporting: rw_done and rw_result always move together.
    if (fail_s) begin
      fidx_s   = idx_r;
      result_s = 1'b0;
      done_s   = 1'b1;
      state_s  = ST_DONE;
    end else if (pass_s) begin
      fidx_s   = 8'd0;
      result_s = 1'b1;
      done_s   = 1'b1;
      state_s  = ST_DONE;
    end else begin
      state_s = state_s;
    end

    busy_s = (state_s != ST_IDLE) && (state_s != ST_DONE);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Counters, captured read data and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r    <= 8'd0;
      gap_r    <= '0;
      tmo_r    <= '0;
      rdata_r  <= 8'd0;
      req_r    <= 1'b0;
      rw_r     <= 1'b0;
      addr_r   <= 8'd0;
      wdata_r  <= 8'd0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      result_r <= 1'b0;
      fidx_r   <= 8'd0;
    end else begin
      idx_r    <= idx_s;
      gap_r    <= gap_s;
      tmo_r    <= tmo_s;
      rdata_r  <= rdata_s;
      req_r    <= req_s;
      rw_r     <= rw_s;
      addr_r   <= addr_s;
      wdata_r  <= wdata_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
      result_r <= result_s;
      fidx_r   <= fidx_s;
    end
  end

  assign i2c_req   = req_r;
  assign i2c_rw    = rw_r;
  assign i2c_addr  = addr_r;
  assign i2c_wdata = wdata_r;
  assign busy      = busy_r;
  assign rw_done   = done_r;
  assign rw_result = result_r;
  assign fail_idx  = fidx_r;

endmodule
